// File: rtl/bs_unrotate_pipe.sv
// bs_unrotate_pipe
//   Pipelined rotator that undoes a barrel-shifter rotate (dir = 0 rotates
//   right) or performs a plain left rotate (dir = 1). There is one register
//   stage per shift-amount bit. Stage k rotates by 2^k when bit k of the beat's
//   amount is set. All stages advance together under a single enable, so
//   bubbles are carried along and are not squeezed out.
//
//   Optional feature macro: BS_UNROT_PARITY_EN. When it is defined, the parity
//   of the input word travels with the beat and is compared at the output.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-high reset (clears all stages)
//   in_valid         input beat valid
//   in_ready         block can accept a beat this cycle (= advance enable)
//   in_data          word to rotate
//   in_shift_amount  rotate amount (SA_WIDTH bits)
//   in_dir           0 = rotate right, 1 = rotate left
//   out_valid        result valid (valid bit of the last stage)
//   out_ready        downstream accepts the result
//   out_data         rotated result
//   out_parity_err   parity mismatch on a valid result (0 without the macro)
module bs_unrotate_pipe #(
  parameter  int DATA_WIDTH = 32,
  localparam int SA_WIDTH   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [SA_WIDTH-1:0]   in_shift_amount,
  input  logic                  in_dir,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_parity_err
);

  localparam int                LAST   = SA_WIDTH - 1;
  localparam logic [SA_WIDTH:0] DW_EXT = (SA_WIDTH + 1)'(DATA_WIDTH);

  // Amounts fit in SA_WIDTH bits, so they are below 2*DATA_WIDTH and a single
  // conditional subtract gives the value modulo DATA_WIDTH. For a power-of-two
  // width the condition can never be true.
  function automatic logic [SA_WIDTH-1:0] reduce_amt(input logic [SA_WIDTH-1:0] a);
    logic [SA_WIDTH:0] a_ext;
    a_ext = {1'b0, a};
    if (a_ext >= DW_EXT) reduce_amt = a - DW_EXT[SA_WIDTH-1:0];
    else                 reduce_amt = a;
  endfunction

  // Rotate by 2^k modulo DATA_WIDTH. The result is taken from the doubled
  // word so that both directions reduce to a single plain shift.
  function automatic logic [DATA_WIDTH-1:0] rot_pow2(input logic [DATA_WIDTH-1:0] x,
                                                     input int k, input logic dir);
    logic [2*DATA_WIDTH-1:0] dbl;
    int                      s;
    s   = (1 << k) % DATA_WIDTH;
    dbl = {x, x};
    if (dir) begin
      dbl      = dbl << s;
      rot_pow2 = dbl[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      dbl      = dbl >> s;
      rot_pow2 = dbl[DATA_WIDTH-1:0];
    end
  endfunction

  logic [SA_WIDTH-1:0]   vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q [SA_WIDTH];
  logic [DATA_WIDTH-1:0] data_d [SA_WIDTH];
  logic [SA_WIDTH-1:0]   amt_q  [SA_WIDTH];
  logic [SA_WIDTH-1:0]   amt_d  [SA_WIDTH];
  logic [SA_WIDTH-1:0]   dir_q, dir_d;
  logic [SA_WIDTH-1:0]   amt0;
  logic                  adv;
`ifdef BS_UNROT_PARITY_EN
  logic [SA_WIDTH-1:0]   par_q, par_d;
`endif

  // Every stage advances together whenever the output slot is empty or draining.
  assign adv      = ~vld_q[LAST] | out_ready;
  assign in_ready = adv;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    amt_d  = amt_q;
    dir_d  = dir_q;
`ifdef BS_UNROT_PARITY_EN
    par_d  = par_q;
`endif
    amt0   = reduce_amt(in_shift_amount);
    if (adv) begin
      // stage 0: capture input, apply the 2^0 rotate
      vld_d[0]  = in_valid;
      amt_d[0]  = amt0;
      dir_d[0]  = in_dir;
      data_d[0] = amt0[0] ? rot_pow2(in_data, 0, in_dir) : in_data;
`ifdef BS_UNROT_PARITY_EN
      par_d[0]  = ^in_data;
`endif
      // stages 1..LAST: stage k applies the 2^k rotate to stage k-1's word
      for (int k = 1; k < SA_WIDTH; k++) begin
        vld_d[k]  = vld_q[k-1];
        amt_d[k]  = amt_q[k-1];
        dir_d[k]  = dir_q[k-1];
        data_d[k] = amt_q[k-1][k] ? rot_pow2(data_q[k-1], k, dir_q[k-1]) : data_q[k-1];
`ifdef BS_UNROT_PARITY_EN
        par_d[k]  = par_q[k-1];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      dir_q <= '0;
      for (int k = 0; k < SA_WIDTH; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
      end
`ifdef BS_UNROT_PARITY_EN
      par_q <= '0;
`endif
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      amt_q  <= amt_d;
      dir_q  <= dir_d;
`ifdef BS_UNROT_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  // output: last stage drives the result directly
  assign out_valid = vld_q[LAST];
  assign out_data  = data_q[LAST];

`ifdef BS_UNROT_PARITY_EN
  // Rotation never changes parity, so a mismatch means the word was corrupted.
  assign out_parity_err = vld_q[LAST] & ((^data_q[LAST]) != par_q[LAST]);
`else
  assign out_parity_err = 1'b0;
`endif

  // The amount and direction of the last stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{amt_q[LAST], dir_q[LAST]};

endmodule

// File: tb/tb_bs_unrotate_pipe.sv
module tb_bs_unrotate_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shift_amount;
  logic        in_dir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_parity_err;

  int vectors    = 0;
  int miscompares = 0;

  // rotr(x,3) for x = 1..8
  logic [31:0] stream_exp [8] = '{32'h2000_0000, 32'h4000_0000, 32'h6000_0000, 32'h8000_0000,
                                  32'hA000_0000, 32'hC000_0000, 32'hE000_0000, 32'h0000_0001};

  bs_unrotate_pipe #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift_amount(in_shift_amount), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity_err(out_parity_err)
  );

  always #5 clk = ~clk;

  // Presents one beat, then waits for its result (bounded).
  task automatic run_single(input logic [31:0] d, input logic [4:0] a, input logic dr,
                            output logic [31:0] res, output int lat, output bit ok);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_shift_amount = a; in_dir = dr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; ok = 1'b0; res = '0;
    while (lat < 20) begin
      if (out_valid) begin
        ok = 1'b1; res = out_data;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    in_shift_amount = 5'd7; in_dir = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || out_parity_err !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_during c=%0d: out_valid=%b out_data=%h in_ready=%b perr=%b, want 0 0 1 0",
                 c, out_valid, out_data, in_ready, out_parity_err);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || out_parity_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_after: out_valid=%b out_data=%h in_ready=%b perr=%b, want 0 0 1 0",
               out_valid, out_data, in_ready, out_parity_err);
    end
  endtask

  task automatic test_rotate();
    logic [31:0] vd  [7] = '{32'h0000_0001, 32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF,
                             32'h8000_0000, 32'h1234_5678, 32'hAABB_CCDD};
    logic [4:0]  va  [7] = '{5'd1, 5'd4, 5'd4, 5'd0, 5'd31, 5'd16, 5'd8};
    logic        vdr [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ve  [7] = '{32'h8000_0000, 32'h8123_4567, 32'h2345_6781, 32'hDEAD_BEEF,
                             32'h0000_0001, 32'h5678_1234, 32'hDDAA_BBCC};
    logic [31:0] res;
    int          lat;
    bit          ok;
    for (int i = 0; i < 7; i++) begin
      run_single(vd[i], va[i], vdr[i], res, lat, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL rotate_timeout[%0d]: no out_valid within %0d cycles, want result after 5", i, lat);
      end else begin
        if (res !== ve[i]) begin
          miscompares++;
          $display("FAIL rotate_data[%0d]: got %h, want %h", i, res, ve[i]);
        end
        vectors++;
        if (lat !== 5) begin
          miscompares++;
          $display("FAIL rotate_latency[%0d]: got %0d, want 5", i, lat);
        end
        vectors++;
        if (out_parity_err !== 1'b0) begin
          miscompares++;
          $display("FAIL rotate_parity[%0d]: got %b, want 0", i, out_parity_err);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit exp_v;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 8); in_data = 32'(c + 1); in_shift_amount = 5'd3; in_dir = 1'b0;
      @(negedge clk);
      exp_v = (c >= 5) && (c < 13);
      vectors++;
      if (out_valid !== exp_v || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_valid c=%0d: out_valid=%b in_ready=%b, want %b 1", c, out_valid, in_ready, exp_v);
      end
      if (exp_v) begin
        vectors++;
        if (out_data !== stream_exp[c-5] || out_parity_err !== 1'b0) begin
          miscompares++;
          $display("FAIL stream_data c=%0d: got %h perr=%b, want %h 0", c, out_data, out_parity_err, stream_exp[c-5]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int          b = 0;
    int          n = 0;
    bit          seen = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] got [8];
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      in_valid = (b < 8); in_data = 32'(b + 1); in_shift_amount = 5'd3; in_dir = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1; held = out_data;
        end else begin
          vectors++;
          if (out_data !== held) begin
            miscompares++;
            $display("FAIL bp_stable c=%0d: got %h, want %h", c, out_data, held);
          end
        end
      end
      if (in_valid && in_ready) b++;
    end
    vectors++;
    if (b !== 5 || in_ready !== 1'b0 || out_valid !== 1'b1 || held !== stream_exp[0]) begin
      miscompares++;
      $display("FAIL bp_fill: accepted=%0d in_ready=%b out_valid=%b head=%h, want 5 0 1 %h",
               b, in_ready, out_valid, held, stream_exp[0]);
    end
    for (int c = 0; c < 40 && n < 8; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = (b < 8); in_data = 32'(b + 1);
      @(negedge clk);
      if (out_valid) begin
        got[n] = out_data;
        n++;
      end
      if (in_valid && in_ready) b++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (n !== 8 || b !== 8) begin
      miscompares++;
      $display("FAIL bp_drain: results=%0d accepted=%0d, want 8 8", n, b);
    end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (got[i] !== stream_exp[i]) begin
        miscompares++;
        $display("FAIL bp_order[%0d]: got %h, want %h", i, got[i], stream_exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 3); in_data = 32'hF0 + 32'(c); in_shift_amount = 5'd2; in_dir = 1'b1;
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h3C0) begin
      miscompares++;
      $display("FAIL midrst_before: out_valid=%b out_data=%h, want 1 000003c0", out_valid, out_data);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_now: out_valid=%b out_data=%h in_ready=%b, want 0 0 1", out_valid, out_data, in_ready);
    end
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || out_parity_err !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_stale c=%0d: out_valid=%b perr=%b, want 0 0", c, out_valid, out_parity_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
